lut_dump_capture_ctrl: RTL



---
 rtl/lut_dump_pkg.sv | 20 ++
 rtl/lut_dump_arm_edge.sv | 26 ++
 rtl/lut_dump_capture_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/lut_dump_pkg.sv
// lut_dump_pkg
//   Shared types and default sizes for the DAC LUT dump capture block.
//   - lut_dump_state_e : capture controller state encoding
//   - LUT_DUMP_ADDR_W  : default buffer port-A address width (4096 samples)
//   - LUT_DUMP_DATA_W  : default sample / port-A data width
//   - LUT_DUMP_CSUM_W  : width of the optional capture checksum
package lut_dump_pkg;

   localparam int LUT_DUMP_ADDR_W = 12;
   localparam int LUT_DUMP_DATA_W = 8;
   localparam int LUT_DUMP_CSUM_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } lut_dump_state_e;

endpackage

// File: rtl/lut_dump_arm_edge.sv
// lut_dump_arm_edge
//   Registers the software arm level and flags its rising edge.
//   Ports:
//     clk, rst  : fabric clock, async active-high reset
//     arm       : software arm level (already in the clk domain)
//     arm_rise  : high for the cycle where arm is 1 and its registered copy is 0
module lut_dump_arm_edge (
   input  logic clk,
   input  logic rst,
   input  logic arm,
   output logic arm_rise
);

   logic arm_q;

   // The registered copy resets to 1 so an arm level that is already high
   // when reset releases is not mistaken for a fresh edge: software must
   // drop arm and raise it again to start a capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) arm_q <= 1'b1;
      else     arm_q <= arm;
   end

   assign arm_rise = arm & ~arm_q;

endmodule

// File: rtl/lut_dump_capture_ctrl.sv
// lut_dump_capture_ctrl
//   Captures one full LUT period into the dump buffer (port A). A rising
//   edge of arm arms the block; the first qualified lut_sync starts writing
//   at address 0 and the write at the last address finishes the capture.
//   Dropping arm aborts a capture in progress or clears a finished one.
//   Optional feature macro: LUT_DUMP_CHECKSUM_EN adds a 16-bit wrapping sum
//   of the captured bytes on port checksum.
//   Ports:
//     clk, rst      : fabric clock, async active-high reset
//     arm           : software arm level
//     lut_sync      : marks LUT sample index 0 (qualified by lut_valid)
//     lut_valid     : sample strobe for lut_data
//     lut_data      : LUT sample
//     bram_we       : port-A write enable (registered)
//     bram_en_a     : port-A enable, same as bram_we
//     bram_addr     : port-A write address
//     bram_wr_data  : port-A write data
//     busy          : armed or capturing
//     done          : capture complete, buffer holds one full period
//     checksum      : (LUT_DUMP_CHECKSUM_EN only) sum of written bytes
module lut_dump_capture_ctrl
   import lut_dump_pkg::*;
#(
   parameter int ADDR_W = LUT_DUMP_ADDR_W,
   parameter int DATA_W = LUT_DUMP_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              arm,
   input  logic              lut_sync,
   input  logic              lut_valid,
   input  logic [DATA_W-1:0] lut_data,
   output logic              bram_we,
   output logic              bram_en_a,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_wr_data,
   output logic              busy,
   output logic              done
`ifdef LUT_DUMP_CHECKSUM_EN
   ,
   output logic [LUT_DUMP_CSUM_W-1:0] checksum
`endif
);

   // Index of the last sample; the counter is one bit wider so it can
   // never alias back onto address 0.
   localparam logic [ADDR_W:0] IDX_LAST = {1'b0, {ADDR_W{1'b1}}};
   localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W+1)'(1);

   lut_dump_state_e   state, state_nxt;
   logic [ADDR_W:0]   idx, idx_nxt;
   logic              arm_rise;
   logic              wr;
   logic [ADDR_W-1:0] wr_addr;
   logic              arm_clr;

   lut_dump_arm_edge u_arm_edge (
      .clk      (clk),
      .rst      (rst),
      .arm      (arm),
      .arm_rise (arm_rise)
   );

   // Next state and the write decision for the sample on the inputs this
   // cycle; the write itself is registered and appears next cycle.
   // Aborts look at the live arm level so that no write follows the cycle
   // in which arm is seen low.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      wr        = 1'b0;
      wr_addr   = idx[ADDR_W-1:0];
      arm_clr   = 1'b0;
      case (state)
         IDLE: begin
            if (arm_rise) begin
               state_nxt = ARMED;
               idx_nxt   = '0;
               arm_clr   = 1'b1;
            end
         end
         ARMED: begin
            if (!arm) begin
               state_nxt = IDLE;
            end else if (lut_sync && lut_valid) begin
               wr        = 1'b1;
               wr_addr   = '0;
               idx_nxt   = IDX_ONE;
               state_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            // lut_sync is deliberately ignored here: no mid-capture restart.
            if (!arm) begin
               state_nxt = IDLE;
            end else if (lut_valid) begin
               wr      = 1'b1;
               idx_nxt = idx + IDX_ONE;
               if (idx == IDX_LAST) state_nxt = DONE;
            end
         end
         DONE: begin
            if (!arm) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Status flags are registered from the next state so busy falls and done
   // rises on the same cycle that carries the terminal write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         idx          <= '0;
         bram_we      <= 1'b0;
         bram_addr    <= '0;
         bram_wr_data <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         bram_we <= wr;
         if (wr) begin
            bram_addr    <= wr_addr;
            bram_wr_data <= lut_data;
         end
         busy <= (state_nxt == ARMED) || (state_nxt == CAPTURE);
         done <= (state_nxt == DONE);
      end
   end

   assign bram_en_a = bram_we;

`ifdef LUT_DUMP_CHECKSUM_EN
   // Accumulates alongside the write register so the sum including a byte
   // is visible in the same cycle that byte is written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          checksum <= '0;
      else if (arm_clr) checksum <= '0;
      else if (wr)      checksum <= checksum + LUT_DUMP_CSUM_W'(lut_data);
   end
`else
   // No checksum: arm_clr has no other consumer.
   logic unused_arm_clr;
   assign unused_arm_clr = arm_clr;
`endif

endmodule
